// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace monitor: state encoding, default field widths,
// trace-entry width and saturating counter arithmetic.
package pipe_trace_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_RD_W   = 4;
    localparam int unsigned DEF_CNT_W  = 32;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_MAX_W = 64;

    // Trace entry layout, MSB first: {cycle stamp, pc, rd, data}.
    function automatic int unsigned trace_width(input int unsigned cnt_w,
                                                input int unsigned addr_w,
                                                input int unsigned rd_w,
                                                input int unsigned data_w);
        return cnt_w + addr_w + rd_w + data_w;
    endfunction

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned width);
        logic [SAT_MAX_W-1:0] max_val;
        if (width >= SAT_MAX_W) begin
            max_val = '1;
        end else begin
            max_val = (64'd1 << width) - 64'd1;
        end
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on rdata whenever it is non-empty,
// and rdata reads as zero while empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign count = count_q;

    // A pop frees the slot the simultaneous push needs, so a full FIFO can still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/pipe_trace_monitor.sv
// Retirement trace monitor: captures register writes into a trace FIFO, keeps saturating
// performance counters and ends each run on halt-drain or cycle timeout.
module pipe_trace_monitor
    import pipe_trace_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned RD_W           = DEF_RD_W,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wb_valid,
    input  logic [RD_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        wb_pc,
    input  logic                     halted_in,
    input  logic                     stall_in,
    input  logic                     flush_in,
    input  logic                     tr_ready,
    output logic                     tr_valid,
    output logic [CNT_W-1:0]         tr_cycle,
    output logic [ADDR_W-1:0]        tr_pc,
    output logic [RD_W-1:0]          tr_rd,
    output logic [DATA_W-1:0]        tr_data,
    output logic [$clog2(DEPTH):0]   tr_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retired_count,
    output logic [CNT_W-1:0]         stall_count,
    output logic [CNT_W-1:0]         flush_count,
    output logic [2:0]               state,
    output logic                     done,
    output logic                     timeout
);

    localparam int unsigned       TRACE_W     = trace_width(CNT_W, ADDR_W, RD_W, DATA_W);
    localparam int unsigned       DRAIN_W     = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYCLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               overflow_q, overflow_d;

    logic               start;
    logic               counting;
    logic               at_limit;
    logic               capture;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TRACE_W-1:0] fifo_wdata;
    logic [TRACE_W-1:0] fifo_rdata;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(SAT_MAX_W'(value), CNT_W));
    endfunction

    assign start    = (state_q == ST_IDLE) && enable;
    // Dropping enable freezes the monitor on that very edge.
    assign counting = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && enable;
    assign at_limit = (cycle_q == CYCLE_LIMIT);
    assign capture  = counting && wb_valid && (wb_rd != '0);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (halted_in) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (drain_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cycle_d    = cycle_q;
        retired_d  = retired_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        overflow_d = overflow_q;
        if (start) begin
            cycle_d    = '0;
            retired_d  = '0;
            stall_d    = '0;
            flush_d    = '0;
            overflow_d = 1'b0;
        end else if (counting) begin
            cycle_d = bump(cycle_q);
            if (wb_valid) begin
                retired_d = bump(retired_q);
            end
            if (stall_in) begin
                stall_d = bump(stall_q);
            end
            if (flush_in) begin
                flush_d = bump(flush_q);
            end
            // A push into a full FIFO is only lost when no pop frees a slot this cycle.
            if (capture && fifo_full && !(tr_ready && !fifo_empty)) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            cycle_q    <= '0;
            retired_q  <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            cycle_q    <= cycle_d;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    // Stamp is the cycle count before this cycle's increment.
    assign fifo_wdata = {cycle_q, wb_pc, wb_rd, wb_data};

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .push  (capture),
        .pop   (tr_ready),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (tr_count)
    );

    assign {tr_cycle, tr_pc, tr_rd, tr_data} = fifo_rdata;

    assign tr_valid      = !fifo_empty;
    assign overflow      = overflow_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
    assign stall_count   = stall_q;
    assign flush_count   = flush_q;
    assign state         = state_q;
    assign done          = done_q;
    assign timeout       = timeout_q;

endmodule
